// File: rtl/mode_dispatcher_if.sv
// Front-panel / LCD bundle between the mode dispatcher and its environment.
// master drives the raw inputs, slave is the dispatcher.
interface mode_dispatcher_if #(
  parameter int N_MODES = 8,
  parameter int SEL_W   = 3,
  parameter int BTN_W   = 16,
  parameter int LINE_W  = 128
);
  logic [SEL_W-1:0]            i_sel;
  logic [BTN_W-1:0]            i_btns;
  logic [N_MODES*2*LINE_W-1:0] i_lines;
  logic [N_MODES*BTN_W-1:0]    o_mode_btns;
  logic [LINE_W-1:0]           o_line1;
  logic [LINE_W-1:0]           o_line2;
  logic [SEL_W-1:0]            o_active_mode;
  logic                        o_switching;

  modport master (
    output i_sel, i_btns, i_lines,
    input  o_mode_btns, o_line1, o_line2, o_active_mode, o_switching
  );

  modport slave (
    input  i_sel, i_btns, i_lines,
    output o_mode_btns, o_line1, o_line2, o_active_mode, o_switching
  );
endinterface

// File: rtl/mode_dispatcher.sv
// Routes buttons to the selected mode and its text lines to the LCD, with a
// debounced selector, a "MODE n" banner on switch and held-button blocking.
module mode_dispatcher #(
  parameter int N_MODES      = 8,
  parameter int SEL_W        = 3,
  parameter int BTN_W        = 16,
  parameter int LINE_W       = 128,
  parameter int DEBOUNCE_CYC = 20,
  parameter int HOLD_CYC     = 1000
) (
  input  logic             clk_1kHz,
  input  logic             reset,
  mode_dispatcher_if.slave bus
);

  localparam int CNT_MAX = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [SEL_W:0]   N_MODES_W = (SEL_W+1)'(N_MODES);
  localparam logic [LINE_W-1:0] SPACES   = {(LINE_W/8){8'h20}};

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_BANNER   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  function automatic logic [LINE_W-1:0] banner_line(input logic [SEL_W-1:0] n);
    logic [LINE_W-1:0] l;
    l = SPACES;
    l[LINE_W-1 -: 40]  = 40'h4D4F444520;
    l[LINE_W-41 -: 8]  = 8'h30 + 8'(n);
    return l;
  endfunction

  state_t                   state_q, state_d, from_q, from_d;
  logic [SEL_W-1:0]         sync1_q, sel_s_q;
  logic [SEL_W-1:0]         active_q, active_d, target_q, target_d;
  logic [CNT_W-1:0]         deb_cnt_q, deb_cnt_d, hold_cnt_q, hold_cnt_d;
  logic [N_MODES*BTN_W-1:0] mode_btns_q, mode_btns_d;
  logic [LINE_W-1:0]        line1_q, line1_d, line2_q, line2_d;
  logic                     switching_q;
  logic [SEL_W-1:0]         sel_eff_s;
  logic                     sel_change_s;
  logic [2*LINE_W-1:0]      mode_lines_s;

  // Out-of-range selector codes alias to the committed mode, so they never start a switch.
  assign sel_eff_s    = ({1'b0, sel_s_q} < N_MODES_W) ? sel_s_q : active_q;
  assign sel_change_s = (sel_eff_s != active_q);
  assign mode_lines_s = bus.i_lines[active_q*2*LINE_W +: 2*LINE_W];

  // Next-state logic; a selector change beats every other transition.
  always_comb begin
    state_d    = state_q;
    from_d     = from_q;
    active_d   = active_q;
    target_d   = target_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_ACTIVE, ST_BANNER, ST_RELEASE: begin
        if (sel_change_s) begin
          state_d   = ST_DEBOUNCE;
          from_d    = state_q;
          target_d  = sel_eff_s;
          deb_cnt_d = '0;
        end else if (state_q == ST_BANNER) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
          end else begin
            hold_cnt_d = sat_inc(hold_cnt_q);
          end
        end else if (state_q == ST_RELEASE) begin
          if (bus.i_btns == '0) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DEBOUNCE: begin
        if (!sel_change_s) begin
          // Back out to where we came from; an abandoned banner restarts its hold time.
          state_d    = from_q;
          hold_cnt_d = '0;
        end else if (sel_eff_s != target_q) begin
          target_d  = sel_eff_s;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          active_d   = target_q;
          state_d    = ST_BANNER;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: begin
        state_d = ST_RELEASE;
      end
    endcase
  end

  // Output data selection: only ACTIVE forwards buttons, BANNER overrides the LCD.
  always_comb begin
    mode_btns_d = '0;
    if (state_q == ST_ACTIVE) begin
      mode_btns_d[active_q*BTN_W +: BTN_W] = bus.i_btns;
    end else begin
      mode_btns_d = '0;
    end
    case (state_q)
      ST_BANNER: begin
        line1_d = banner_line(active_q);
        line2_d = SPACES;
      end
      default: begin
        line1_d = mode_lines_s[2*LINE_W-1 -: LINE_W];
        line2_d = mode_lines_s[LINE_W-1:0];
      end
    endcase
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk_1kHz) begin
    if (reset) begin
      state_q     <= ST_RELEASE;
      from_q      <= ST_RELEASE;
      sync1_q     <= '0;
      sel_s_q     <= '0;
      active_q    <= '0;
      target_q    <= '0;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      mode_btns_q <= '0;
      line1_q     <= SPACES;
      line2_q     <= SPACES;
      switching_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      from_q      <= from_d;
      sync1_q     <= bus.i_sel;
      sel_s_q     <= sync1_q;
      active_q    <= active_d;
      target_q    <= target_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mode_btns_q <= mode_btns_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      switching_q <= (state_d != ST_ACTIVE);
    end
  end

  assign bus.o_mode_btns   = mode_btns_q;
  assign bus.o_line1       = line1_q;
  assign bus.o_line2       = line2_q;
  assign bus.o_active_mode = active_q;
  assign bus.o_switching   = switching_q;

endmodule

// File: tb/tb_mode_dispatcher.sv
// Directed bench for mode_dispatcher with short debounce/banner times.
module tb_mode_dispatcher;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int BW = 16;
  localparam int LW = 128;

  logic clk_1kHz = 1'b0;
  logic reset    = 1'b1;
  int   total    = 0;
  int   bad      = 0;

  mode_dispatcher_if #(.N_MODES(N), .SEL_W(SW), .BTN_W(BW), .LINE_W(LW)) bus ();

  mode_dispatcher #(
    .N_MODES(N), .SEL_W(SW), .BTN_W(BW), .LINE_W(LW),
    .DEBOUNCE_CYC(4), .HOLD_CYC(8)
  ) dut (
    .clk_1kHz(clk_1kHz),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  localparam logic [LW-1:0] SPACES = {16{8'h20}};

  function automatic logic [LW-1:0] l1_of(input int k);
    return {16{8'(8'h41 + k)}};
  endfunction

  function automatic logic [LW-1:0] l2_of(input int k);
    return {16{8'(8'h61 + k)}};
  endfunction

  function automatic logic [N*BW-1:0] btn_vec(input int k, input logic [BW-1:0] v);
    logic [N*BW-1:0] r;
    r = '0;
    r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_1kHz);
    #1;
  endtask

  task automatic switch_to(input logic [SW-1:0] m);
    bus.i_sel = m;
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_reset();
    bus.i_sel  = '0;
    bus.i_btns = '0;
    reset = 1'b1;
    tick();
    tick();
    total++; if (bus.o_mode_btns !== '0) begin bad++; $display("FAIL rst_btns got=%h want=0", bus.o_mode_btns); end
    total++; if (bus.o_active_mode !== 3'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", bus.o_active_mode); end
    total++; if (bus.o_line1 !== SPACES || bus.o_line2 !== SPACES) begin bad++; $display("FAIL rst_lines got=%h/%h want spaces", bus.o_line1, bus.o_line2); end
    total++; if (bus.o_switching !== 1'b1) begin bad++; $display("FAIL rst_switching got=%b want=1", bus.o_switching); end
    reset = 1'b0;
    tick();
    total++; if (bus.o_switching !== 1'b0) begin bad++; $display("FAIL rst_to_active got=%b want=0", bus.o_switching); end
    total++; if (bus.o_line1 !== l1_of(0) || bus.o_line2 !== l2_of(0)) begin bad++; $display("FAIL rst_mode0_lines got=%h/%h", bus.o_line1, bus.o_line2); end
  endtask

  task automatic test_buttons();
    bus.i_btns = 16'h0004;
    tick();
    total++; if (bus.o_mode_btns !== btn_vec(0, 16'h0004)) begin bad++; $display("FAIL btn_0004 got=%h want=%h", bus.o_mode_btns, btn_vec(0, 16'h0004)); end
    bus.i_btns = 16'hA5A5;
    tick();
    total++; if (bus.o_mode_btns !== btn_vec(0, 16'hA5A5)) begin bad++; $display("FAIL btn_a5a5 got=%h want=%h", bus.o_mode_btns, btn_vec(0, 16'hA5A5)); end
    bus.i_btns = '0;
    tick();
    total++; if (bus.o_mode_btns !== '0) begin bad++; $display("FAIL btn_clear got=%h want=0", bus.o_mode_btns); end
  endtask

  task automatic test_switch();
    logic [LW-1:0] ban;
    ban = "MODE 3          ";
    bus.i_sel = 3'd3;
    tick();
    tick();
    total++; if (bus.o_switching !== 1'b0) begin bad++; $display("FAIL sw_early got=%b want=0", bus.o_switching); end
    tick();
    total++; if (bus.o_switching !== 1'b1) begin bad++; $display("FAIL sw_rise got=%b want=1", bus.o_switching); end
    tick(); tick(); tick();
    total++; if (bus.o_active_mode !== 3'd0) begin bad++; $display("FAIL sw_precommit got=%0d want=0", bus.o_active_mode); end
    tick();
    total++; if (bus.o_active_mode !== 3'd3) begin bad++; $display("FAIL sw_commit got=%0d want=3", bus.o_active_mode); end
    total++; if (bus.o_line1 !== l1_of(0)) begin bad++; $display("FAIL sw_old_lines got=%h want=%h", bus.o_line1, l1_of(0)); end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (bus.o_line1 !== ban || bus.o_line2 !== SPACES) begin
        bad++; $display("FAIL sw_banner[%0d] got=%h/%h want=%h/spaces", i, bus.o_line1, bus.o_line2, ban);
      end
    end
    tick();
    total++; if (bus.o_line1 !== l1_of(3) || bus.o_line2 !== l2_of(3)) begin bad++; $display("FAIL sw_mode3_lines got=%h/%h", bus.o_line1, bus.o_line2); end
    total++; if (bus.o_switching !== 1'b0) begin bad++; $display("FAIL sw_done got=%b want=0", bus.o_switching); end
  endtask

  task automatic test_glitch();
    switch_to(3'd0);
    bus.i_btns = 16'h0008;
    bus.i_sel  = 3'd3;
    tick();
    tick();
    bus.i_sel = 3'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.o_mode_btns[3*BW +: BW] !== '0 || bus.o_active_mode !== 3'd0) begin
        bad++; $display("FAIL glitch_cyc[%0d] got mode=%0d slice3=%h want 0/0", i, bus.o_active_mode, bus.o_mode_btns[3*BW +: BW]);
      end
    end
    total++; if (bus.o_switching !== 1'b0) begin bad++; $display("FAIL glitch_active got=%b want=0", bus.o_switching); end
    total++; if (bus.o_mode_btns !== btn_vec(0, 16'h0008)) begin bad++; $display("FAIL glitch_btns got=%h want=%h", bus.o_mode_btns, btn_vec(0, 16'h0008)); end
    bus.i_btns = '0;
    tick();
  endtask

  task automatic test_held_button();
    bus.i_btns = 16'h0001;
    tick();
    total++; if (bus.o_mode_btns !== btn_vec(0, 16'h0001)) begin bad++; $display("FAIL held_pre got=%h want=%h", bus.o_mode_btns, btn_vec(0, 16'h0001)); end
    bus.i_sel = 3'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (bus.o_mode_btns[2*BW +: BW] !== '0) begin
        bad++; $display("FAIL held_slice2[%0d] got=%h want=0", i, bus.o_mode_btns[2*BW +: BW]);
      end
    end
    total++; if (bus.o_active_mode !== 3'd2 || bus.o_switching !== 1'b1) begin bad++; $display("FAIL held_release got mode=%0d sw=%b want 2/1", bus.o_active_mode, bus.o_switching); end
    total++; if (bus.o_line1 !== l1_of(2)) begin bad++; $display("FAIL held_lines got=%h want=%h", bus.o_line1, l1_of(2)); end
    bus.i_btns = '0;
    tick();
    total++; if (bus.o_switching !== 1'b0) begin bad++; $display("FAIL held_to_active got=%b want=0", bus.o_switching); end
    bus.i_btns = 16'h0002;
    tick();
    total++; if (bus.o_mode_btns !== btn_vec(2, 16'h0002)) begin bad++; $display("FAIL held_new_press got=%h want=%h", bus.o_mode_btns, btn_vec(2, 16'h0002)); end
    bus.i_btns = '0;
    tick();
  endtask

  task automatic test_reset_mid_banner();
    logic [LW-1:0] ban;
    ban = "MODE 5          ";
    bus.i_sel = 3'd5;
    for (int i = 0; i < 9; i++) tick();
    total++; if (bus.o_line1 !== ban || bus.o_active_mode !== 3'd5) begin bad++; $display("FAIL mid_banner got=%h mode=%0d want=%h/5", bus.o_line1, bus.o_active_mode, ban); end
    reset = 1'b1;
    tick();
    total++; if (bus.o_active_mode !== 3'd0 || bus.o_switching !== 1'b1) begin bad++; $display("FAIL mid_rst got mode=%0d sw=%b want 0/1", bus.o_active_mode, bus.o_switching); end
    total++; if (bus.o_line1 !== SPACES || bus.o_line2 !== SPACES) begin bad++; $display("FAIL mid_rst_lines got=%h/%h want spaces", bus.o_line1, bus.o_line2); end
    bus.i_sel = 3'd0;
    reset = 1'b0;
    tick();
    total++; if (bus.o_switching !== 1'b0 || bus.o_line1 !== l1_of(0)) begin bad++; $display("FAIL mid_recover got sw=%b l1=%h want 0/%h", bus.o_switching, bus.o_line1, l1_of(0)); end
  endtask

  initial begin
    bus.i_sel   = '0;
    bus.i_btns  = '0;
    bus.i_lines = '0;
    for (int k = 0; k < N; k++) begin
      bus.i_lines[k*2*LW +: 2*LW] = {l1_of(k), l2_of(k)};
    end
    test_reset();
    test_buttons();
    test_switch();
    test_glitch();
    test_held_button();
    test_reset_mid_banner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
